// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the programmable sequence detector.
package seq_det_pkg;

  // Storage width of the config struct. Instances keep MAX_LEN below PAT_MAX and
  // only use the low bits of each field.
  localparam int unsigned PAT_MAX   = 64;
  localparam int unsigned LEN_MAX_W = 8;

  // Defaults reproduce the legacy overlapping 1010 Mealy detector.
  localparam logic [PAT_MAX-1:0]   DEF_PATTERN = PAT_MAX'(4'b1010);
  localparam logic [LEN_MAX_W-1:0] DEF_LEN     = LEN_MAX_W'(4);
  localparam logic                 DEF_OVERLAP = 1'b1;
  localparam logic                 DEF_MOORE   = 1'b0;

  typedef struct packed {
    logic [PAT_MAX-1:0]   pattern;
    logic [LEN_MAX_W-1:0] len;
    logic                 overlap;
    logic                 moore;
  } cfg_t;

  function automatic cfg_t cfg_default();
    cfg_t c;
    c.pattern = DEF_PATTERN;
    c.len     = DEF_LEN;
    c.overlap = DEF_OVERLAP;
    c.moore   = DEF_MOORE;
    return c;
  endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked compare of the newest len bits of {hist, i_bit} against the pattern.
module seq_match_cmp #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic               i_bit,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               eq
);

  logic [MAX_LEN:0] window;
  logic [MAX_LEN:0] pat_ext;
  logic [MAX_LEN:0] mask;

  assign window  = {hist, i_bit};
  assign pat_ext = {1'b0, pattern};

  // Keep only bit positions below len; the newest bit sits at position 0.
  always_comb begin
    mask = '0;
    for (int i = 0; i <= int'(MAX_LEN); i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign eq = (((window ^ pat_ext) & mask) == '0);

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial sequence detector with runtime pattern, overlap and
// Mealy/Moore selection plus a saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_bit,
  input  logic               i_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_moore,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  cfg_t               cfg_q, cfg_d;
  logic               cfg_err_q, cfg_err_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               y_q, y_d;

  logic [MAX_LEN-1:0] pat_act;
  logic [LEN_W-1:0]   len_act;
  logic [LEN_W:0]     fill_plus1;
  logic               consume;
  logic               cmp_eq;
  logic               match_now;
  logic               cfg_len_bad;
  logic               unused_cfg_hi;

  assign pat_act = cfg_q.pattern[MAX_LEN-1:0];
  assign len_act = cfg_q.len[LEN_W-1:0];

  // Upper storage bits of the struct are never written with nonzero data.
  assign unused_cfg_hi = ^{cfg_q.pattern[PAT_MAX-1:MAX_LEN], cfg_q.len[LEN_MAX_W-1:LEN_W]};

  // A bit presented together with a load is dropped.
  assign consume     = i_valid & ~cfg_load;
  assign fill_plus1  = {1'b0, fill_q} + 1'b1;
  assign cfg_len_bad = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));

  seq_match_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist    (hist_q),
    .i_bit   (i_bit),
    .pattern (pat_act),
    .len     (len_act),
    .eq      (cmp_eq)
  );

  assign match_now = consume & ~cfg_err_q & (fill_plus1 >= {1'b0, len_act}) & cmp_eq;

  // Next-state for config, history, fill, counter and Moore output register.
  always_comb begin
    cfg_d     = cfg_q;
    cfg_err_d = cfg_err_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    y_d       = match_now;
    if (cfg_load) begin
      cfg_d.pattern = PAT_MAX'(cfg_pattern);
      cfg_d.len     = LEN_MAX_W'(cfg_len);
      cfg_d.overlap = cfg_overlap;
      cfg_d.moore   = cfg_moore;
      cfg_err_d     = cfg_len_bad;
      hist_d        = '0;
      fill_d        = '0;
      cnt_d         = '0;
      y_d           = 1'b0;
    end else if (consume) begin
      hist_d = {hist_q[MAX_LEN-2:0], i_bit};
      if (match_now && !cfg_q.overlap) begin
        fill_d = '0;
      end else if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_d = fill_plus1[LEN_W-1:0];
      end
      if (match_now && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q     <= cfg_default();
      cfg_err_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      y_q       <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      cfg_err_q <= cfg_err_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
    end
  end

  assign y         = cfg_q.moore ? y_q : match_now;
  assign match_cnt = cnt_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench: directed scenarios plus random traffic against a
// bit-history reference model.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_bit, i_valid, cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap, cfg_moore;
  logic               y;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  int total = 0;
  int bad   = 0;

  // Reference model: config plus the consumed bits since reset/load.
  logic [7:0] m_pat;
  int         m_len, m_since, m_cnt;
  bit         m_ovl, m_moore, m_err, m_yreg;
  bit         m_q[$];

  seq_detector_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_bit       (i_bit),
    .i_valid     (i_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_moore   (cfg_moore),
    .y           (y),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pat = 8'b1010; m_len = 4; m_ovl = 1'b1; m_moore = 1'b0; m_err = 1'b0;
    m_yreg = 1'b0; m_since = 0; m_cnt = 0;
    m_q.delete();
  endtask

  // True when the last m_len consumed bits (ending with b) spell the pattern,
  // enough fresh bits have arrived and the config is usable.
  function automatic bit model_match(bit b, bit v, bit ld);
    bit newest;
    if (!v || ld || m_err) return 1'b0;
    if (m_since + 1 < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++) begin
      newest = (j == 0) ? b : m_q[m_q.size() - j];
      if (newest != m_pat[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: drive, check at the falling edge, advance the model after the rising edge.
  task automatic step(input bit b, input bit v, input bit ld, input string tag);
    bit mnow;
    i_bit = b; i_valid = v; cfg_load = ld;
    @(negedge clk);
    mnow = model_match(b, v, ld);
    check_eq({tag, ".y"}, 32'(y), 32'(m_moore ? m_yreg : mnow));
    check_eq({tag, ".cnt"}, 32'(match_cnt), 32'(m_cnt));
    check_eq({tag, ".err"}, 32'(cfg_err), 32'(m_err));
    @(posedge clk);
    #1;
    if (ld) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; m_moore = cfg_moore;
      m_err = (cfg_len == 0) || (int'(cfg_len) > MAX_LEN);
      m_q.delete(); m_since = 0; m_cnt = 0; m_yreg = 1'b0;
    end else begin
      m_yreg = mnow;
      if (v) begin
        m_q.push_back(b);
        if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
        m_since = (mnow && !m_ovl) ? 0 : m_since + 1;
        if (mnow && m_cnt < CNT_MAX) m_cnt++;
      end
    end
    i_valid = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic send(input logic [31:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, "idle");
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl, input bit moore);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_moore = moore;
    step(1'b0, 1'b0, 1'b1, "load");
  endtask

  task automatic peek(input string tag, input logic [31:0] got, input logic [31:0] exp);
    @(negedge clk);
    check_eq(tag, got, exp);
    @(posedge clk);
    #1;
    m_yreg = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_bit = 1'b0; i_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_moore = 1'b0;
    model_reset();
    #12;
    check_eq("rst.y", 32'(y), 0);
    check_eq("rst.cnt", 32'(match_cnt), 0);
    check_eq("rst.err", 32'(cfg_err), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Legacy overlapping Mealy 1010.
    send(32'b1010100, 7, "t1");
    check_eq("t1.total", 32'(match_cnt), 2);

    // Non-overlapping.
    load(8'b1010, 4'd4, 1'b0, 1'b0);
    send(32'b1010100, 7, "t2a");
    send(32'b1010, 4, "t2b");
    check_eq("t2.total", 32'(match_cnt), 2);

    // Moore: pulse one cycle after the final bit.
    load(8'b1010, 4'd4, 1'b1, 1'b1);
    send(32'b1010, 4, "t3");
    peek("t3.pulse", 32'(y), 1);
    peek("t3.after", 32'(y), 0);

    // Full-length pattern with a valid gap.
    load(8'hA5, 4'd8, 1'b1, 1'b0);
    send(32'b1010, 4, "t4a");
    idle(3);
    send(32'b0101, 4, "t4b");
    check_eq("t4.total", 32'(match_cnt), 1);

    // Invalid length, recovery, load with valid.
    load(8'b1010, 4'd0, 1'b1, 1'b0);
    check_eq("t5.err_set", 32'(cfg_err), 1);
    send(32'b1010, 4, "t5a");
    check_eq("t5.no_cnt", 32'(match_cnt), 0);
    load(8'b1010, 4'd9, 1'b1, 1'b0);
    check_eq("t5.err_9", 32'(cfg_err), 1);
    load(8'b1010, 4'd4, 1'b1, 1'b0);
    check_eq("t5.err_clr", 32'(cfg_err), 0);
    send(32'b1010, 4, "t5b");
    check_eq("t5.resume", 32'(match_cnt), 1);
    step(1'b1, 1'b1, 1'b1, "t5ld");
    send(32'b010, 3, "t5c");
    check_eq("t5.ignored", 32'(match_cnt), 0);

    // Saturation, then reset mid-pattern.
    load(8'b1010, 4'd4, 1'b1, 1'b0);
    send(32'hAAA, 12, "t6");
    check_eq("t6.sat", 32'(match_cnt), CNT_MAX);
    send(32'b101, 3, "t6p");
    rst = 1'b0;
    #2;
    check_eq("t6.rst_y", 32'(y), 0);
    check_eq("t6.rst_cnt", 32'(match_cnt), 0);
    check_eq("t6.rst_err", 32'(cfg_err), 0);
    model_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 1'b1, 1'b0, "t6z");

    // Random traffic with occasional reconfiguration.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        cfg_pattern = 8'($urandom);
        cfg_len     = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(1, 4));
        cfg_overlap = 1'($urandom);
        cfg_moore   = 1'($urandom);
        step(1'($urandom), 1'($urandom), 1'b1, "rnd_ld");
      end else begin
        step(1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
